// File: rtl/aes_pkg.sv
// aes_pkg: shared types and helpers for the iterative AES encryptor.
//   fsm_e      - controller states
//   nr()       - round count for a key length in words
//   xtime()    - GF(2^8) multiply by x
//   byte_lsb() - bit position of state byte i (byte 0 in [127:120])
//   sr_src()   - ShiftRows source byte index
//   sbox()     - forward S-box lookup
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  function automatic int unsigned nr(input int unsigned nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // State bytes are column-major: byte i is row i%4, column i/4
  function automatic int unsigned byte_lsb(input int unsigned i);
    return 120 - 8 * i;
  endfunction

  // Row r is rotated left by r, so out[r][c] = in[r][(c+r)%4]
  function automatic int unsigned sr_src(input int unsigned i);
    return (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
  endfunction

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b occupies [2047-8b -: 8]; 2047-8b == {~b, 3'b111}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[{~b, 3'b111} -: 8];
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// aes_key_expand_step: one on-the-fly key schedule step (combinational).
//   key       - current key register (32*NK bits, word 0 in the MSBs)
//   rcon      - current round constant
//   odd       - round number parity; selects AES-256 odd/even behaviour
//   key_next  - key register value after this round
//   rcon_next - round constant after this round
//   rk        - round key applied in this round
module aes_key_expand_step
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  logic [32*NK-1:0] key,
  input  logic [7:0]       rcon,
  input  logic             odd,
  output logic [32*NK-1:0] key_next,
  output logic [7:0]       rcon_next,
  output logic [127:0]     rk
);

  logic [31:0]  last_w;
  logic [31:0]  rot_w;
  logic [31:0]  sub_rot;
  logic [127:0] hi;
  logic [31:0]  g0, g1, g2, g3;
  logic [127:0] new_hi;

  assign last_w = key[31:0];
  assign rot_w  = {last_w[23:0], last_w[31:24]};
  assign hi     = key[32*NK-1 -: 128];

  for (genvar i = 0; i < 4; i++) begin : g_rot_sbox
    aes_sbox u_sbox (
      .x(rot_w[31-8*i -: 8]),
      .y(sub_rot[31-8*i -: 8])
    );
  end

  assign g0     = hi[127:96] ^ sub_rot ^ {rcon, 24'h000000};
  assign g1     = hi[95:64] ^ g0;
  assign g2     = hi[63:32] ^ g1;
  assign g3     = hi[31:0] ^ g2;
  assign new_hi = {g0, g1, g2, g3};

  if (NK == 4) begin : g_aes128
    logic unused_odd;
    assign unused_odd = odd;
    assign key_next   = new_hi;
    assign rcon_next  = xtime(rcon);
    assign rk         = new_hi;
  end else begin : g_aes256
    logic [127:0] lo;
    logic [31:0]  sub_g3;
    logic [31:0]  h0, h1, h2, h3;

    assign lo = key[127:0];

    // Word 4 of the step depends on word 3 of the same step, so it needs
    // its own S-boxes to finish the 8-word expansion in one cycle.
    for (genvar i = 0; i < 4; i++) begin : g_w4_sbox
      aes_sbox u_sbox (
        .x(g3[31-8*i -: 8]),
        .y(sub_g3[31-8*i -: 8])
      );
    end

    assign h0 = lo[127:96] ^ sub_g3;
    assign h1 = lo[95:64] ^ h0;
    assign h2 = lo[63:32] ^ h1;
    assign h3 = lo[31:0] ^ h2;

    always_comb begin
      key_next  = key;
      rcon_next = rcon;
      rk        = lo;
      if (!odd) begin
        key_next  = {new_hi, h0, h1, h2, h3};
        rcon_next = xtime(rcon);
        rk        = new_hi;
      end
    end
  end

endmodule

// File: rtl/aes_mixw.sv
// aes_mixw: MixColumns applied to one 32-bit column.
//   w - column, row 0 in [31:24]
//   y - mixed column, same layout
module aes_mixw
  import aes_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] y
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = w;

  assign y = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};

endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box.
//   x - input byte
//   y - substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = sbox(x);

endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128/AES-256 block encryptor, one round per
// clock, round keys generated on the fly, valid/ready on both sides.
//   clk        - clock
//   nreset     - asynchronous active-low reset
//   data_v_i   - plaintext valid
//   data_rdy_o - plaintext ready (follows res_rdy_i while a result is held)
//   data_i     - plaintext, state byte 0 in [127:120]
//   key_i      - cipher key (32*NK bits), key byte 0 in the MSBs
//   res_v_o    - ciphertext valid
//   res_rdy_i  - consumer ready
//   res_o      - ciphertext, same byte order as data_i
//   busy_o     - rounds in progress
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            data_v_i,
  output logic            data_rdy_o,
  input  logic [127:0]    data_i,
  input  logic [32*NK-1:0] key_i,
  output logic            res_v_o,
  input  logic            res_rdy_i,
  output logic [127:0]    res_o,
  output logic            busy_o
);

  if (NK != 4 && NK != 8) begin : g_bad_nk
    $error("aes_enc_iter: NK must be 4 (AES-128) or 8 (AES-256)");
  end

  localparam logic [3:0] NR_LAST = 4'(nr(NK));

  fsm_e             fsm;
  logic [127:0]     state_q;
  logic [32*NK-1:0] key_q;
  logic [7:0]       rcon_q;
  logic [3:0]       round_q;
  logic             rdy_q;

  logic [127:0]     subbed;
  logic [127:0]     shifted;
  logic [127:0]     mixed;
  logic [127:0]     rk;
  logic [127:0]     round_state;
  logic [32*NK-1:0] key_next;
  logic [7:0]       rcon_next;
  logic             accept;

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .x(state_q[127-8*i -: 8]),
      .y(subbed[127-8*i -: 8])
    );
  end

  always_comb begin
    shifted = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      shifted[byte_lsb(i) +: 8] = subbed[byte_lsb(sr_src(i)) +: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mixw u_mixw (
      .w(shifted[127-32*c -: 32]),
      .y(mixed[127-32*c -: 32])
    );
  end

  aes_key_expand_step #(
    .NK(NK)
  ) u_key_step (
    .key      (key_q),
    .rcon     (rcon_q),
    .odd      (round_q[0]),
    .key_next (key_next),
    .rcon_next(rcon_next),
    .rk       (rk)
  );

  assign round_state = ((round_q == NR_LAST) ? shifted : mixed) ^ rk;

  // Ready is registered in IDLE; in DONE it passes res_rdy_i through so a
  // result hand-off and the next accept can share one edge.
  assign data_rdy_o = rdy_q | (res_v_o & res_rdy_i);
  assign accept     = data_v_i & data_rdy_o;
  assign res_o      = state_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fsm     <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rcon_q  <= '0;
      round_q <= '0;
      rdy_q   <= 1'b1;
      res_v_o <= 1'b0;
      busy_o  <= 1'b0;
    end else if (accept) begin
      fsm     <= ROUND;
      state_q <= data_i ^ key_i[32*NK-1 -: 128];
      key_q   <= key_i;
      rcon_q  <= 8'h01;
      round_q <= 4'd1;
      rdy_q   <= 1'b0;
      res_v_o <= 1'b0;
      busy_o  <= 1'b1;
    end else begin
      case (fsm)
        IDLE: ;
        ROUND: begin
          state_q <= round_state;
          key_q   <= key_next;
          rcon_q  <= rcon_next;
          if (round_q == NR_LAST) begin
            fsm     <= DONE;
            res_v_o <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          if (res_rdy_i) begin
            fsm     <= IDLE;
            res_v_o <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: directed bench for aes_enc_iter with one AES-128 and one
// AES-256 instance, using FIPS-197 known-answer vectors.
module tb_aes_enc_iter;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         nreset;

  logic         a_data_v, a_data_rdy, a_res_v, a_res_rdy, a_busy;
  logic [127:0] a_data, a_key, a_res;

  logic         b_data_v, b_data_rdy, b_res_v, b_res_rdy, b_busy;
  logic [127:0] b_data, b_res;
  logic [255:0] b_key;

  int unsigned  errors = 0;
  int unsigned  checks = 0;

  always #5 clk = ~clk;

  aes_enc_iter #(.NK(4)) u_dut128 (
    .clk       (clk),
    .nreset    (nreset),
    .data_v_i  (a_data_v),
    .data_rdy_o(a_data_rdy),
    .data_i    (a_data),
    .key_i     (a_key),
    .res_v_o   (a_res_v),
    .res_rdy_i (a_res_rdy),
    .res_o     (a_res),
    .busy_o    (a_busy)
  );

  aes_enc_iter #(.NK(8)) u_dut256 (
    .clk       (clk),
    .nreset    (nreset),
    .data_v_i  (b_data_v),
    .data_rdy_o(b_data_rdy),
    .data_i    (b_data),
    .key_i     (b_key),
    .res_v_o   (b_res_v),
    .res_rdy_i (b_res_rdy),
    .res_o     (b_res),
    .busy_o    (b_busy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present one block, let it be accepted on the next edge, then scramble
  // the inputs (they must be ignored while the block is in flight).
  task automatic start(input bit sel, input logic [127:0] data, input logic [255:0] key,
                       input string tag);
    if (sel) begin
      b_data_v = 1'b1; b_data = data; b_key = key;
    end else begin
      a_data_v = 1'b1; a_data = data; a_key = key[127:0];
    end
    @(posedge clk); #1;
    a_data_v = 1'b0; b_data_v = 1'b0;
    a_data = rnd128(); a_key = rnd128();
    b_data = rnd128(); b_key = {rnd128(), rnd128()};
    check({tag, " busy/rdy/resv after accept"},
          256'(sel ? {b_busy, b_data_rdy, b_res_v} : {a_busy, a_data_rdy, a_res_v}), 256'(3'b100));
  endtask

  // Count edges after the accept edge until res_v rises (bounded).
  task automatic wait_done(input bit sel, input int unsigned lat, input logic [127:0] ct,
                           input string tag);
    int unsigned n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      seen = sel ? b_res_v : a_res_v;
    end
    check({tag, " latency"}, 256'(n), 256'(lat));
    check({tag, " ciphertext"}, 256'(sel ? b_res : a_res), 256'(ct));
    check({tag, " busy/rdy in DONE"},
          256'(sel ? {b_busy, b_data_rdy} : {a_busy, a_data_rdy}), 256'(2'b00));
  endtask

  task automatic release_result(input bit sel, input string tag);
    if (sel) b_res_rdy = 1'b1; else a_res_rdy = 1'b1;
    #1;
    check({tag, " rdy follows res_rdy"}, 256'(sel ? b_data_rdy : a_data_rdy), 256'(1));
    @(posedge clk); #1;
    a_res_rdy = 1'b0; b_res_rdy = 1'b0;
    check({tag, " idle after take"},
          256'(sel ? {b_res_v, b_data_rdy, b_busy} : {a_res_v, a_data_rdy, a_busy}), 256'(3'b010));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bb_pt [8];
    logic [127:0] bb_key[8];
    logic [127:0] bb_ct [8];
    int unsigned  n;
    int unsigned  stale;
    bit           seen;

    nreset   = 1'b1;
    a_data_v = 1'b0; a_res_rdy = 1'b0; a_data = '0; a_key = '0;
    b_data_v = 1'b0; b_res_rdy = 1'b0; b_data = '0; b_key = '0;
    #2 nreset = 1'b0;
    #10;
    check("reset a flags", 256'({a_data_rdy, a_res_v, a_busy}), 256'(3'b100));
    check("reset a res_o", 256'(a_res), 256'(0));
    check("reset b flags", 256'({b_data_rdy, b_res_v, b_busy}), 256'(3'b100));
    check("reset b res_o", 256'(b_res), 256'(0));
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 Appendix B, AES-128
    start(1'b0, PT_B, {128'h0, KEY_B}, "B");
    wait_done(1'b0, 10, CT_B, "B");

    // Backpressure: result held, new block offered but not taken
    a_data_v = 1'b1; a_data = PT_C; a_key = KEY_C1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold res_o", 256'(a_res), 256'(CT_B));
      check("hold resv/rdy/busy", 256'({a_res_v, a_data_rdy, a_busy}), 256'(3'b100));
    end
    a_res_rdy = 1'b1;
    #1;
    check("overlap rdy comb", 256'(a_data_rdy), 256'(1));
    @(posedge clk); #1;
    a_res_rdy = 1'b0; a_data_v = 1'b0;
    a_data = rnd128(); a_key = rnd128();
    check("overlap accept", 256'({a_res_v, a_data_rdy, a_busy}), 256'(3'b001));
    wait_done(1'b0, 10, CT_C1, "C.1 overlap");
    release_result(1'b0, "C.1 overlap");

    // FIPS-197 C.3, AES-256
    start(1'b1, PT_C, KEY_C3, "C.3");
    wait_done(1'b1, 14, CT_C3, "C.3");
    release_result(1'b1, "C.3");

    // Back-to-back with res_rdy tied high, alternating C.1 and B
    for (int k = 0; k < 8; k++) begin
      bb_pt[k]  = (k % 2 == 0) ? PT_C   : PT_B;
      bb_key[k] = (k % 2 == 0) ? KEY_C1 : KEY_B;
      bb_ct[k]  = (k % 2 == 0) ? CT_C1  : CT_B;
    end
    a_res_rdy = 1'b1; a_data_v = 1'b1; a_data = bb_pt[0]; a_key = bb_key[0];
    @(posedge clk); #1;
    a_data = bb_pt[1]; a_key = bb_key[1];
    for (int k = 0; k < 8; k++) begin
      n = 0; seen = 1'b0;
      while (!seen && n < 30) begin
        @(posedge clk); #1;
        n++;
        if (n == 1 && k > 0) begin
          if (k < 7) begin
            a_data = bb_pt[k+1]; a_key = bb_key[k+1];
          end else begin
            a_data_v = 1'b0;
          end
        end
        seen = a_res_v;
      end
      check($sformatf("b2b[%0d] interval", k), 256'(n), 256'(k == 0 ? 10 : 11));
      check($sformatf("b2b[%0d] ciphertext", k), 256'(a_res), 256'(bb_ct[k]));
    end
    @(posedge clk); #1;
    a_res_rdy = 1'b0;
    check("b2b drain idle", 256'({a_res_v, a_data_rdy, a_busy}), 256'(3'b010));

    // Asynchronous reset during round 5
    start(1'b0, PT_C, {128'h0, KEY_C1}, "reset run");
    repeat (4) begin
      @(posedge clk); #1;
    end
    nreset = 1'b0;
    #2;
    check("mid reset flags", 256'({a_res_v, a_data_rdy, a_busy}), 256'(3'b010));
    check("mid reset res_o", 256'(a_res), 256'(0));
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (a_res_v || !a_data_rdy) stale++;
    end
    check("no stale result", 256'(stale), 256'(0));
    start(1'b0, PT_C, {128'h0, KEY_C1}, "C.1 after reset");
    wait_done(1'b0, 10, CT_C1, "C.1 after reset");
    release_result(1'b0, "C.1 after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
